// File: rtl/fe51_pack_stream_pkg.sv
// Shared types and constants for the GF(2^255-19) field-element datapath.
package fe51_pack_stream_pkg;

    // Five 51-bit limbs held in 64-bit containers, limb 0 least significant.
    typedef logic [4:0][63:0] fe51_t;

    localparam logic [63:0] LIMB_MASK   = 64'h0007_FFFF_FFFF_FFFF;
    localparam logic [63:0] FE_P_LIMB0  = 64'h0007_FFFF_FFFF_FFED;
    localparam int          FE_BYTES    = 32;
    localparam logic [63:0] FE_REDUCE_K = 64'd19;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CARRY1,
        S_CARRY2,
        S_FREEZE,
        S_PACK,
        S_STREAM
    } state_e;

endpackage

// File: rtl/fe51_pack_stream_freeze.sv
// Constant-time final reduction: maps a weakly reduced element (< 2p) to [0, p).
module fe51_freeze
    import fe51_pack_stream_pkg::*;
(
    input  fe51_t h_in,
    output fe51_t h_out
);

    logic [63:0] t;
    logic [63:0] q;
    logic [63:0] c;

    // q = 1 exactly when h >= p, found as the carry out of bit 255 of h+19;
    // adding 19*q and dropping bit 255 then subtracts p without branching.
    always_comb begin
        t = h_in[0] + FE_REDUCE_K;
        q = t >> 51;
        for (int i = 1; i < 5; i++) begin
            t = h_in[i] + q;
            q = t >> 51;
        end
        h_out    = h_in;
        h_out[0] = h_in[0] + FE_REDUCE_K * q;
        for (int i = 0; i < 4; i++) begin
            c            = h_out[i] >> 51;
            h_out[i]     = h_out[i] & LIMB_MASK;
            h_out[i + 1] = h_out[i + 1] + c;
        end
        h_out[4] = h_out[4] & LIMB_MASK;
    end

endmodule

// File: rtl/fe51_pack_stream.sv
// Canonicalizing encoder: reduces a loose 5x51 element mod 2^255-19 and
// streams its 32-byte little-endian encoding over a valid/ready handshake.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start; input latched on acceptance
// S_CARRY1 | first full carry pass over the limbs
// S_CARRY2 | second carry pass; value now < 2^255 + 2^13
// S_FREEZE | conditional subtract of p, result in [0, p)
// S_PACK   | limbs packed into the 256-bit shift register, counter cleared
// S_STREAM | one byte per handshake, LSB first; byte 31 returns to idle
module fe51_pack_stream
    import fe51_pack_stream_pkg::*;
#(
    parameter int LOOSE_BITS = 54
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  fe51_t      in,
    output logic       busy,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_byte,
    output logic       out_last
);

    // Bits above the legal limb width carry no meaning, so they are dropped on capture.
    localparam logic [63:0] LOOSE_MASK =
        (LOOSE_BITS >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << LOOSE_BITS) - 64'd1);
    localparam logic [4:0] LAST_IDX = 5'(FE_BYTES - 1);

    state_e       state_q, state_d;
    fe51_t        h_q, h_d;
    fe51_t        h_frz;
    logic [255:0] sreg_q, sreg_d;
    logic [4:0]   cnt_q, cnt_d;

    function automatic fe51_t carry_pass(input fe51_t a);
        fe51_t       r;
        logic [63:0] c;
        r = a;
        for (int i = 0; i < 4; i++) begin
            c        = r[i] >> 51;
            r[i]     = r[i] & LIMB_MASK;
            r[i + 1] = r[i + 1] + c;
        end
        c    = r[4] >> 51;
        r[4] = r[4] & LIMB_MASK;
        r[0] = r[0] + FE_REDUCE_K * c;
        return r;
    endfunction

    fe51_freeze u_freeze (
        .h_in  (h_q),
        .h_out (h_frz)
    );

    // Next-state and datapath updates; every state advances unconditionally
    // except idle (waits for start) and stream (waits for each handshake).
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    for (int i = 0; i < 5; i++) h_d[i] = in[i] & LOOSE_MASK;
                    state_d = S_CARRY1;
                end
            end
            S_CARRY1: begin
                h_d     = carry_pass(h_q);
                state_d = S_CARRY2;
            end
            S_CARRY2: begin
                h_d     = carry_pass(h_q);
                state_d = S_FREEZE;
            end
            S_FREEZE: begin
                h_d     = h_frz;
                state_d = S_PACK;
            end
            S_PACK: begin
                sreg_d  = {1'b0, h_q[4][50:0], h_q[3][50:0], h_q[2][50:0],
                           h_q[1][50:0], h_q[0][50:0]};
                cnt_d   = 5'd0;
                state_d = S_STREAM;
            end
            S_STREAM: begin
                if (out_ready) begin
                    sreg_d = sreg_q >> 8;
                    cnt_d  = cnt_q + 5'd1;
                    if (cnt_q == LAST_IDX) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, limb and shift-register flops; reset abandons any stream in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            h_q     <= '0;
            sreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_STREAM);
    assign out_byte  = out_valid ? sreg_q[7:0] : 8'h00;
    assign out_last  = out_valid && (cnt_q == LAST_IDX);

endmodule

// File: tb/tb_fe51_pack_stream.sv
// Self-checking bench for fe51_pack_stream against an integer mod-p reference.
module tb_fe51_pack_stream;
    import fe51_pack_stream_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       out_ready = 1'b0;
    fe51_t      in_el = '0;
    logic       busy, out_valid, out_last;
    logic [7:0] out_byte;

    int total = 0;
    int bad   = 0;

    localparam logic [63:0] M51 = (64'd1 << 51) - 64'd1;

    always #5 clk = ~clk;

    fe51_pack_stream #(.LOOSE_BITS(54)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in        (in_el),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_byte  (out_byte),
        .out_last  (out_last)
    );

    // Reference: value = sum limb_i * 2^(51 i), reduced with a plain modulo.
    function automatic logic [255:0] ref_enc(input fe51_t x);
        logic [319:0] v;
        logic [319:0] p;
        v = '0;
        for (int i = 0; i < 5; i++) v = v + (320'(x[i]) << (51 * i));
        p = (320'd1 << 255) - 320'd19;
        v = v % p;
        return v[255:0];
    endfunction

    function automatic fe51_t rnd_fe(input int bits);
        fe51_t       r;
        logic [63:0] m;
        m = (64'd1 << bits) - 64'd1;
        for (int i = 0; i < 5; i++) r[i] = {$urandom, $urandom} & m;
        return r;
    endfunction

    function automatic fe51_t mk(input logic [63:0] l0, input logic [63:0] lh);
        fe51_t r;
        r[0] = l0;
        for (int i = 1; i < 5; i++) r[i] = lh;
        return r;
    endfunction

    // Caller must be positioned just after a falling edge.
    task automatic run_one(input fe51_t x, input bit stall, input bit noise, input string name);
        logic [255:0] e_enc;
        int cyc, idx, stall_left, budget;
        e_enc = ref_enc(x);
        start = 1'b1;
        in_el = x;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in_el = rnd_fe(54);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL %s busy_after_start got=%0b exp=1", name, busy);
        end
        cyc = 1;
        while (out_valid !== 1'b1 && cyc < 12) begin
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                in_el = rnd_fe(54);
            end
            @(negedge clk);
            cyc++;
        end
        total++;
        if (out_valid !== 1'b1 || cyc != 5) begin
            bad++;
            $display("FAIL %s first_valid got_cycle=%0d exp_cycle=5", name, cyc);
        end
        idx = 0;
        budget = 0;
        stall_left = stall ? $urandom_range(0, 5) : 0;
        while (idx < 32 && budget < 400) begin
            total++;
            if (out_valid !== 1'b1) begin
                bad++;
                $display("FAIL %s valid_dropped byte=%0d got=%0b exp=1", name, idx, out_valid);
                break;
            end
            total++;
            if (out_last !== (idx == 31)) begin
                bad++;
                $display("FAIL %s out_last byte=%0d got=%0b exp=%0b", name, idx, out_last, idx == 31);
            end
            total++;
            if (out_byte !== e_enc[idx*8 +: 8]) begin
                bad++;
                $display("FAIL %s byte%0d got=%02h exp=%02h stalled=%0b", name, idx, out_byte,
                         e_enc[idx*8 +: 8], stall_left > 0);
            end
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                in_el = rnd_fe(54);
            end
            if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = 1'b1;
                idx++;
                stall_left = stall ? $urandom_range(0, 5) : 0;
            end
            @(negedge clk);
            budget++;
        end
        start = 1'b0;
        total++;
        if (idx != 32) begin
            bad++;
            $display("FAIL %s stream_incomplete got_bytes=%0d exp=32", name, idx);
        end
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s busy_fall got_busy=%0b got_valid=%0b exp=0", name, busy, out_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({busy, out_valid, out_last, out_byte} !== 11'h0) begin
            bad++;
            $display("FAIL reset_outputs got busy=%0b valid=%0b last=%0b byte=%02h exp all 0",
                     busy, out_valid, out_last, out_byte);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_vectors();
        fe51_t x;
        run_one('0, 1'b0, 1'b0, "zero");
        run_one(mk(M51 - 64'd18, M51), 1'b0, 1'b0, "p");
        run_one(mk(M51 - 64'd19, M51), 1'b0, 1'b0, "p_minus_1");
        run_one(mk(M51 - 64'd17, M51), 1'b0, 1'b0, "p_plus_1");
        x = '0;
        x[0] = (64'd1 << 52) - 64'd1;
        run_one(x, 1'b0, 1'b0, "loose52");
        run_one(mk((64'd1 << 54) - 64'd1, (64'd1 << 54) - 64'd1), 1'b0, 1'b0, "max_loose");
    endtask

    task automatic test_random();
        for (int n = 0; n < 15; n++) run_one(rnd_fe(54), 1'b0, 1'b0, "random");
        for (int n = 0; n < 5; n++) run_one(rnd_fe(51), 1'b0, 1'b0, "random51");
    endtask

    task automatic test_backpressure();
        fe51_t x;
        x = rnd_fe(54);
        run_one(x, 1'b0, 1'b0, "bp_ref_unstalled");
        run_one(x, 1'b1, 1'b1, "bp_same_stalled");
        for (int n = 0; n < 8; n++) run_one(rnd_fe(54), 1'b1, 1'b1, "bp_random");
    endtask

    task automatic test_back_to_back();
        // Each run starts in the very cycle busy has fallen.
        for (int n = 0; n < 3; n++) run_one(rnd_fe(54), 1'b0, 1'b0, "back_to_back");
    endtask

    task automatic test_reset_abort();
        fe51_t one;
        start = 1'b1;
        in_el = mk(M51 - 64'd19, M51);
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, out_valid, out_last, out_byte} !== 11'h0) begin
            bad++;
            $display("FAIL reset_abort got busy=%0b valid=%0b last=%0b byte=%02h exp all 0",
                     busy, out_valid, out_last, out_byte);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        one = '0;
        one[0] = 64'd1;
        run_one(one, 1'b0, 1'b0, "after_reset_one");
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
